// File: rtl/synapse_rc_mem.sv
// Synapse weight memory: integer RAM plus a small associative rich-club fractional table, LFSR fractions otherwise.
// Optional build macro SYN_RC_REPLACE_EN: round-robin replacement on a full table instead of dropping the write.
module synapse_rc_mem #(
    parameter int          ADDR_W    = 7,
    parameter int          INT_W     = 8,
    parameter int          FRAC_W    = 8,
    parameter int          RC_DEPTH  = 4,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      kill,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_we,
    input  logic                      req_rc,
    input  logic [ADDR_W-1:0]         req_addr,
    input  logic [INT_W+FRAC_W-1:0]   req_data,
    output logic                      rsp_valid,
    output logic [INT_W+FRAC_W-1:0]   rsp_weight,
    output logic                      rsp_rc_hit,
    output logic                      rc_full,
    output logic                      rc_drop
);
    localparam int PTR_W = $clog2(RC_DEPTH);

    logic [INT_W-1:0]   ram [2**ADDR_W];
    logic [INT_W-1:0]   ram_q;
    logic [RC_DEPTH-1:0] rc_valid;
    logic [ADDR_W-1:0]  rc_tag  [RC_DEPTH];
    logic [FRAC_W-1:0]  rc_frac [RC_DEPTH];

    logic               accept, wr_acc, rd_acc;
    logic               hit, free, tbl_we, drop;
    logic [PTR_W-1:0]   hit_idx, free_idx, tbl_idx;
    logic [FRAC_W-1:0]  hit_frac;
    logic [RC_DEPTH-1:0] valid_next;

    logic               s1_valid, s1_zero, s1_hit;
    logic [FRAC_W-1:0]  s1_frac;
    logic [15:0]        lfsr, lfsr_next;

`ifdef SYN_RC_REPLACE_EN
    logic [PTR_W-1:0]   rr_ptr;
    logic               bump;
`endif

    assign req_ready = !rst && !kill;
    assign accept    = req_valid && req_ready;
    assign wr_acc    = accept && req_we;
    assign rd_acc    = accept && !req_we;
    assign lfsr_next = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};

    // Tag lookup shared by reads and writes; iterating downward lets the lowest index win.
    always_comb begin
        hit      = 1'b0;
        hit_idx  = '0;
        hit_frac = '0;
        free     = 1'b0;
        free_idx = '0;
        for (int i = RC_DEPTH - 1; i >= 0; i--) begin
            if (!rc_valid[i]) begin
                free     = 1'b1;
                free_idx = PTR_W'(i);
            end
            if (rc_valid[i] && rc_tag[i] == req_addr) begin
                hit      = 1'b1;
                hit_idx  = PTR_W'(i);
                hit_frac = rc_frac[i];
            end
        end
    end

    always_comb begin
        tbl_we = 1'b0;
        tbl_idx = hit_idx;
        drop   = 1'b0;
`ifdef SYN_RC_REPLACE_EN
        bump   = 1'b0;
`endif
        if (wr_acc && req_rc) begin
            if (hit) begin
                tbl_we = 1'b1;
            end else if (free) begin
                tbl_we  = 1'b1;
                tbl_idx = free_idx;
            end else begin
`ifdef SYN_RC_REPLACE_EN
                tbl_we  = 1'b1;
                tbl_idx = rr_ptr;
                bump    = 1'b1;
`else
                drop    = 1'b1;
`endif
            end
        end
        valid_next = rc_valid;
        if (tbl_we)
            valid_next[tbl_idx] = 1'b1;
    end

    // Read port runs every cycle so a write lands before a read accepted in the following cycle.
    always_ff @(posedge clk) begin
        if (wr_acc)
            ram[req_addr] <= req_data[INT_W+FRAC_W-1:FRAC_W];
        ram_q <= ram[req_addr];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rc_valid <= '0;
            rc_full  <= 1'b0;
            rc_drop  <= 1'b0;
`ifdef SYN_RC_REPLACE_EN
            rr_ptr   <= '0;
`endif
        end else if (kill) begin
            rc_valid <= '0;
            rc_full  <= 1'b0;
            rc_drop  <= 1'b0;
        end else begin
            rc_valid <= valid_next;
            rc_full  <= &valid_next;
            rc_drop  <= drop;
            if (tbl_we) begin
                rc_tag[tbl_idx]  <= req_addr;
                rc_frac[tbl_idx] <= req_data[FRAC_W-1:0];
            end
`ifdef SYN_RC_REPLACE_EN
            if (bump)
                rr_ptr <= rr_ptr + 1'b1;
`endif
        end
    end

    // Two-stage read pipe: capture lookup with the RAM read, then assemble and register the response.
    always_ff @(posedge clk) begin
        if (rst || kill) begin
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= rd_acc;
            s1_zero  <= (req_addr == '0);
            s1_hit   <= req_rc && hit;
            s1_frac  <= hit_frac;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid  <= 1'b0;
            rsp_weight <= '0;
            rsp_rc_hit <= 1'b0;
            lfsr       <= LFSR_SEED;
        end else if (kill) begin
            rsp_valid  <= 1'b0;
        end else begin
            rsp_valid <= s1_valid;
            if (s1_valid) begin
                if (s1_zero) begin
                    rsp_weight <= '0;
                    rsp_rc_hit <= 1'b0;
                end else if (s1_hit) begin
                    rsp_weight <= {ram_q, s1_frac};
                    rsp_rc_hit <= 1'b1;
                end else begin
                    rsp_weight <= {ram_q, lfsr_next[FRAC_W-1:0]};
                    rsp_rc_hit <= 1'b0;
                    lfsr       <= lfsr_next;
                end
            end
        end
    end
endmodule

// File: tb/tb_synapse_rc_mem.sv
// Directed bench for synapse_rc_mem; expected weights and LFSR fractions are hand-computed from seed 16'hACE1.
module tb_synapse_rc_mem;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        kill = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic        req_rc = 1'b0;
    logic [6:0]  req_addr = '0;
    logic [15:0] req_data = '0;
    logic        rsp_valid;
    logic [15:0] rsp_weight;
    logic        rsp_rc_hit;
    logic        rc_full;
    logic        rc_drop;

`ifdef SYN_RC_REPLACE_EN
    localparam bit REPLACE = 1'b1;
`else
    localparam bit REPLACE = 1'b0;
`endif

    typedef struct {
        logic [15:0] weight;
        logic        hit;
        int          due;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    int   streak = 0;
    int   max_streak = 0;

    synapse_rc_mem dut (
        .clk(clk), .rst(rst), .kill(kill),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_rc(req_rc),
        .req_addr(req_addr), .req_data(req_data),
        .rsp_valid(rsp_valid), .rsp_weight(rsp_weight), .rsp_rc_hit(rsp_rc_hit),
        .rc_full(rc_full), .rc_drop(rc_drop)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, observed, expected, cyc);
        end
    endtask

    // Drives one request for a single cycle; reads with expect_rsp queue their response and due cycle.
    task automatic applyStimulus(input logic we, input logic rc, input logic [6:0] addr,
                                 input logic [15:0] data, input logic expect_rsp,
                                 input logic [15:0] exp_weight, input logic exp_hit);
        exp_t e;
        req_valid = 1'b1;
        req_we    = we;
        req_rc    = rc;
        req_addr  = addr;
        req_data  = data;
        if (expect_rsp) begin
            e.weight = exp_weight;
            e.hit    = exp_hit;
            e.due    = cyc + 2;
            exp_q.push_back(e);
        end
        @(negedge clk);
        req_valid = 1'b0;
        req_we    = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rsp_valid) begin
            streak++;
            if (streak > max_streak)
                max_streak = streak;
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_rsp", 32'(rsp_valid), 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                checkOutput("rsp_weight", 32'(rsp_weight), 32'(e.weight));
                checkOutput("rsp_rc_hit", 32'(rsp_rc_hit), 32'(e.hit));
                checkOutput("rsp_latency", 32'(cyc), 32'(e.due));
            end
        end else begin
            streak = 0;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("reset_rsp_weight", 32'(rsp_weight), 32'd0);
        checkOutput("reset_rsp_rc_hit", 32'(rsp_rc_hit), 32'd0);
        checkOutput("reset_rc_full", 32'(rc_full), 32'd0);
        checkOutput("reset_rc_drop", 32'(rc_drop), 32'd0);
        checkOutput("ready_in_reset", 32'(req_ready), 32'd0);
        rst = 1'b0;
        #1 checkOutput("ready_after_reset", 32'(req_ready), 32'd1);
        @(negedge clk);

        // Rich-club write then hit
        applyStimulus(1'b1, 1'b1, 7'd5, 16'h3A7F, 1'b0, 16'h0, 1'b0);
        applyStimulus(1'b0, 1'b1, 7'd5, 16'h0, 1'b1, 16'h3A7F, 1'b1);

        // LFSR fractions: states after 16'hACE1 are 5670, AB38, 559C, 2ACE, 1567
        applyStimulus(1'b1, 1'b0, 7'd9, 16'h1234, 1'b0, 16'h0, 1'b0);
        applyStimulus(1'b0, 1'b0, 7'd9, 16'h0, 1'b1, 16'h1270, 1'b0);
        applyStimulus(1'b0, 1'b0, 7'd9, 16'h0, 1'b1, 16'h1238, 1'b0);

        // Address zero reads as zero and leaves the LFSR alone
        applyStimulus(1'b0, 1'b0, 7'd0, 16'h0, 1'b1, 16'h0000, 1'b0);
        applyStimulus(1'b0, 1'b0, 7'd9, 16'h0, 1'b1, 16'h129C, 1'b0);

        // Fill the table (5 already present)
        applyStimulus(1'b1, 1'b1, 7'd1, 16'h1111, 1'b0, 16'h0, 1'b0);
        applyStimulus(1'b1, 1'b1, 7'd2, 16'h2222, 1'b0, 16'h0, 1'b0);
        checkOutput("rc_full_three", 32'(rc_full), 32'd0);
        applyStimulus(1'b1, 1'b1, 7'd3, 16'h3333, 1'b0, 16'h0, 1'b0);
        checkOutput("rc_full_four", 32'(rc_full), 32'd1);

        applyStimulus(1'b1, 1'b1, 7'd6, 16'h6655, 1'b0, 16'h0, 1'b0);
        checkOutput("rc_drop_pulse", 32'(rc_drop), 32'(!REPLACE));
        @(negedge clk);
        checkOutput("rc_drop_clear", 32'(rc_drop), 32'd0);
        checkOutput("rc_full_kept", 32'(rc_full), 32'd1);

        applyStimulus(1'b0, 1'b1, 7'd6, 16'h0, 1'b1, REPLACE ? 16'h6655 : 16'h66CE, REPLACE);
        applyStimulus(1'b0, 1'b1, 7'd5, 16'h0, 1'b1, REPLACE ? 16'h3ACE : 16'h3A7F, !REPLACE);

        // Hit update immediately followed by a read of the same address
        applyStimulus(1'b1, 1'b1, 7'd3, 16'h77AB, 1'b0, 16'h0, 1'b0);
        applyStimulus(1'b0, 1'b1, 7'd3, 16'h0, 1'b1, 16'h77AB, 1'b1);
        repeat (3) @(negedge clk);

        // Kill squashes an in-flight read and empties the table
        checkOutput("rc_full_before_kill", 32'(rc_full), 32'd1);
        applyStimulus(1'b0, 1'b1, 7'd2, 16'h0, 1'b0, 16'h0, 1'b0);
        kill = 1'b1;
        #1 checkOutput("ready_in_kill", 32'(req_ready), 32'd0);
        @(negedge clk);
        kill = 1'b0;
        checkOutput("rc_full_after_kill", 32'(rc_full), 32'd0);
        repeat (3) @(negedge clk);
        applyStimulus(1'b0, 1'b1, 7'd2, 16'h0, 1'b1, 16'h2267, 1'b0);
        repeat (3) @(negedge clk);

        // Write-then-read and a nine-deep read stream
        max_streak = 0;
        applyStimulus(1'b1, 1'b1, 7'd7, 16'hA5C3, 1'b0, 16'h0, 1'b0);
        applyStimulus(1'b0, 1'b1, 7'd7, 16'h0, 1'b1, 16'hA5C3, 1'b1);
        for (int i = 0; i < 8; i++)
            applyStimulus(1'b0, 1'b1, 7'd7, 16'h0, 1'b1, 16'hA5C3, 1'b1);
        repeat (4) @(negedge clk);
        checkOutput("stream_len", 32'(max_streak), 32'd9);
        checkOutput("pending", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
